// File: rtl/waterlight_pkg.sv
// Shared definitions for the WaterLight AHB-Lite peripheral: register
// offsets (HADDR[3:2]) and the LED pattern mode encoding.
package waterlight_pkg;

  localparam logic [1:0] OFF_MODE  = 2'd0;
  localparam logic [1:0] OFF_SPEED = 2'd1;
  localparam logic [1:0] OFF_LED   = 2'd2;

  typedef enum logic [1:0] {
    MODE_STOP  = 2'd0,
    MODE_LEFT  = 2'd1,
    MODE_RIGHT = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

endpackage

// File: rtl/waterlight_engine.sv
// WaterLight pattern engine: a 32-bit prescaler that produces one tick every
// speed+1 cycles, and the LED pattern register that advances on each tick.
// A mode write reloads the pattern; either register write restarts the
// prescaler and swallows any tick that would have landed in that cycle.
module waterlight_engine
  import waterlight_pkg::*;
#(
  parameter int LED_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  mode_e            mode,      // already reflects a mode write in progress
  input  logic [31:0]      speed,
  input  logic             mode_wr,
  input  logic             speed_wr,
  output logic [LED_W-1:0] led
);

  localparam logic [LED_W-1:0] LED_LSB = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0] LED_MSB = {1'b1, {(LED_W-1){1'b0}}};

  logic [31:0]      cnt_reg;
  logic [LED_W-1:0] led_reg;
  logic             tick;

  // Pattern value loaded when a new mode is written.
  function automatic logic [LED_W-1:0] load_value(input mode_e m);
    case (m)
      MODE_LEFT:  load_value = LED_LSB;
      MODE_RIGHT: load_value = LED_MSB;
      MODE_BLINK: load_value = '1;
      default:    load_value = '0;
    endcase
  endfunction

  // One pattern step for the current mode.
  function automatic logic [LED_W-1:0] step_value(input mode_e m, input logic [LED_W-1:0] v);
    case (m)
      MODE_LEFT:  step_value = {v[LED_W-2:0], v[LED_W-1]};
      MODE_RIGHT: step_value = {v[0], v[LED_W-1:1]};
      MODE_BLINK: step_value = ~v;
      default:    step_value = '0;
    endcase
  endfunction

  assign tick = (mode != MODE_STOP) && (cnt_reg >= speed);
  assign led  = led_reg;

  // Prescaler and pattern register; writes take priority over the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      led_reg <= '0;
    end else if (mode_wr) begin
      cnt_reg <= '0;
      led_reg <= load_value(mode);
    end else if (speed_wr) begin
      cnt_reg <= '0;
    end else if (mode == MODE_STOP) begin
      cnt_reg <= '0;
      led_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
      led_reg <= step_value(mode, led_reg);
    end else begin
      cnt_reg <= cnt_reg + 32'd1;
    end
  end

endmodule

// File: rtl/ahblite_waterlight.sv
// AHB-Lite slave for the WaterLight peripheral. Captures the address phase,
// commits writes to MODE/SPEED at the end of the data phase, serves reads
// from a combinational mux, and hands the pattern work to waterlight_engine.
// Zero wait states, always OKAY.
module ahblite_waterlight
  import waterlight_pkg::*;
#(
  parameter int          LED_W     = 8,
  parameter logic [31:0] SPEED_RST = 32'd1_000_000
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic [2:0]       HSIZE,
  input  logic [3:0]       HPROT,
  input  logic             HWRITE,
  input  logic [31:0]      HWDATA,
  input  logic             HREADY,
  output logic             HREADYOUT,
  output logic             HRESP,
  output logic [31:0]      HRDATA,
  output logic [LED_W-1:0] LED
);

  logic        valid_reg;
  logic        write_reg;
  logic [1:0]  offset_reg;
  mode_e       mode_reg;
  logic [31:0] speed_reg;

  logic        accept;
  logic        mode_wr;
  logic        speed_wr;
  mode_e       mode_next;
  logic        unused_bits;

  assign accept    = HSEL & HTRANS[1] & HREADY;
  assign mode_wr   = valid_reg & write_reg & (offset_reg == OFF_MODE);
  assign speed_wr  = valid_reg & write_reg & (offset_reg == OFF_SPEED);
  assign mode_next = mode_wr ? mode_e'(HWDATA[1:0]) : mode_reg;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  // Size, protection and byte-lane address bits play no part in this slave.
  assign unused_bits = ^{HSIZE, HPROT, HADDR[31:4], HADDR[1:0]};

  // Address-phase capture; valid drops whenever no transfer is accepted.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid_reg  <= 1'b0;
      write_reg  <= 1'b0;
      offset_reg <= 2'd0;
    end else begin
      valid_reg <= accept;
      if (accept) begin
        write_reg  <= HWRITE;
        offset_reg <= HADDR[3:2];
      end
    end
  end

  // MODE/SPEED registers, written at the end of the data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mode_reg  <= MODE_STOP;
      speed_reg <= SPEED_RST;
    end else begin
      if (mode_wr)  mode_reg  <= mode_e'(HWDATA[1:0]);
      if (speed_wr) speed_reg <= HWDATA;
    end
  end

  // Read mux from the registered offset; reserved slot reads zero.
  always_comb begin
    HRDATA = '0;
    case (offset_reg)
      OFF_MODE:  HRDATA = {30'd0, mode_reg};
      OFF_SPEED: HRDATA = speed_reg;
      OFF_LED:   HRDATA = 32'(LED);
      default:   HRDATA = '0;
    endcase
  end

  waterlight_engine #(
    .LED_W(LED_W)
  ) u_engine (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .mode     (mode_next),
    .speed    (speed_reg),
    .mode_wr  (mode_wr),
    .speed_wr (speed_wr),
    .led      (LED)
  );

endmodule
